sum_tx_sequencer: RTL and testbench

Control block for the sum/latch/UART datapath. It debounces the two active-low save buttons, latches the operand A and operand B nibbles, and forms their sum. On each save-B press it sequences the UART transmitter to send one ASCII frame: the sum as hex characters, then CR, then LF. It sits between the top-level pad inputs and the UART TX, and owns the tx_start/tx_busy handshake.

---
 rtl/sum_tx_pkg.sv | 23 ++
 rtl/button_debounce.sv | 53 +++++
 rtl/sum_tx_sequencer.sv | 133 +++++++++++++
 tb/tb_sum_tx_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sum_tx_pkg.sv
// rtl/sum_tx_pkg.sv - shared states, ASCII constants and hex helper for the sum/TX sequencer
package sum_tx_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    ACK  = 3'd3,
    WAIT = 3'd4
  } seq_state_e;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A_M10 = 8'h37;

  // 'A' - 10, so nibbles 10..15 land on 0x41..0x46
  function automatic logic [7:0] hex_to_ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) return ASCII_0 + {4'b0000, nibble};
    else                return ASCII_A_M10 + {4'b0000, nibble};
  endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - active-low button synchronizer, debouncer and press-pulse generator
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   stable_q, stable_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   press_q, press_d;
  logic                   synced;

  assign synced  = sync_q[SYNC_STAGES-1];
  assign press_o = press_q;

  // Any cycle that agrees with the accepted level restarts the count, so glitches vanish.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (synced != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = synced;
        press_d  = ~synced;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q[0] <= btn_n_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

endmodule

// File: rtl/sum_tx_sequencer.sv
// rtl/sum_tx_sequencer.sv - latches operands from debounced buttons and sends their sum as a hex/CR/LF UART frame
module sum_tx_sequencer
  import sum_tx_pkg::*;
#(
  parameter int DATA_W          = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              save_a_n,
  input  logic              save_b_n,
  input  logic [DATA_W-1:0] data_input,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [DATA_W-1:0] operand_a,
  output logic [DATA_W-1:0] operand_b,
  output logic [DATA_W:0]   sum_out,
  output logic              seq_busy
);

  localparam int SUM_W     = DATA_W + 1;
  localparam int NUM_HEX   = (SUM_W + 3) / 4;
  localparam int FRAME_LEN = NUM_HEX + 2;
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic press_a, press_b;

  seq_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SUM_W-1:0]  snap_q, snap_d;
  logic              pend_q, pend_d;
  logic [7:0]        txd_q, txd_d;
  logic [DATA_W-1:0] opa_q, opb_q;
  logic [SUM_W-1:0]  sum_q;
  logic [SUM_W-1:0]  sum_now;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_deb_a (
    .clk     (clk),
    .rst_n   (reset_n),
    .btn_n_i (save_a_n),
    .press_o (press_a)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_deb_b (
    .clk     (clk),
    .rst_n   (reset_n),
    .btn_n_i (save_b_n),
    .press_o (press_b)
  );

  function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx,
                                            input logic [SUM_W-1:0] s);
    logic [4*NUM_HEX-1:0] padded;
    logic [7:0]           b;
    padded = (4*NUM_HEX)'(s);
    b      = ASCII_LF;
    if (idx == IDX_W'(NUM_HEX)) b = ASCII_CR;
    for (int i = 0; i < NUM_HEX; i++)
      if (idx == IDX_W'(i)) b = hex_to_ascii(padded[4*(NUM_HEX-1-i) +: 4]);
    return b;
  endfunction

  // Taken straight from the operand registers: sum_q lags a same-cycle latch by one clock.
  assign sum_now = SUM_W'(opa_q) + SUM_W'(opb_q);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    snap_d   = snap_q;
    pend_d   = pend_q;
    txd_d    = txd_q;
    tx_start = 1'b0;
    case (state_q)
      IDLE: if (press_b || pend_q) state_d = LOAD;
      LOAD: begin
        snap_d  = sum_now;
        idx_d   = '0;
        pend_d  = 1'b0;
        txd_d   = frame_byte('0, sum_now);
        state_d = SEND;
      end
      SEND: if (!tx_busy) begin
        tx_start = 1'b1;
        state_d  = ACK;
      end
      ACK:  state_d = WAIT;
      WAIT: if (!tx_busy) begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          txd_d   = frame_byte(idx_q + IDX_W'(1), snap_q);
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
    // A press during LOAD misses the snapshot, so it must queue a frame too.
    if (press_b && state_q != IDLE) pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
      pend_q  <= 1'b0;
      txd_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      pend_q  <= pend_d;
      txd_q   <= txd_d;
      if (press_a) opa_q <= data_input;
      if (press_b) opb_q <= data_input;
      sum_q   <= sum_now;
    end
  end

  assign tx_data   = txd_q;
  assign operand_a = opa_q;
  assign operand_b = opb_q;
  assign sum_out   = sum_q;
  assign seq_busy  = (state_q != IDLE) || pend_q;

endmodule

// File: tb/tb_sum_tx_sequencer.sv
// tb/tb_sum_tx_sequencer.sv - scoreboard bench for sum_tx_sequencer with a 10-cycle-busy UART model
module tb_sum_tx_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       save_a_n = 1'b1;
  logic       save_b_n = 1'b1;
  logic [3:0] data_input = 4'h0;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] operand_a, operand_b;
  logic [4:0] sum_out;
  logic       seq_busy;

  int         n_checks = 0;
  int         n_fail = 0;
  int         start_cnt = 0;
  int         busy_cnt = 0;
  logic [7:0] exp_q[$];
  logic       hold_arm = 1'b0;
  logic [7:0] hold_val = 8'h00;

  always #5 clk = ~clk;

  sum_tx_sequencer #(.DATA_W(4), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .save_a_n   (save_a_n),
    .save_b_n   (save_b_n),
    .data_input (data_input),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .sum_out    (sum_out),
    .seq_busy   (seq_busy)
  );

  // UART model: busy for 10 cycles after each accepted tx_start.
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every tx_start and checks the hold window.
  always @(negedge clk) begin
    if (!reset_n) begin
      hold_arm <= 1'b0;
    end else begin
      if (hold_arm && tx_busy) check("tx_data_hold", tx_data, hold_val);
      if (tx_start) begin
        start_cnt++;
        check("start_while_idle_uart", tx_busy, 1'b0);
        if (exp_q.size() == 0) begin
          check("unexpected_tx_start", 1, 0);
        end else begin
          check("tx_byte", tx_data, exp_q.pop_front());
        end
        hold_arm <= 1'b1;
        hold_val <= tx_data;
      end else if (!tx_busy) begin
        hold_arm <= 1'b0;
      end
    end
  end

  task automatic press(input logic is_b, input logic [3:0] d, input int low_cycles);
    @(posedge clk); #2;
    data_input = d;
    if (is_b) save_b_n = 1'b0; else save_a_n = 1'b0;
    repeat (low_cycles) @(posedge clk);
    #2;
    save_a_n = 1'b1;
    save_b_n = 1'b1;
    repeat (8) @(posedge clk);
  endtask

  task automatic push_frame(input logic [7:0] h, input logic [7:0] l);
    exp_q.push_back(h);
    exp_q.push_back(l);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (seq_busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle_timeout"}, seq_busy, 1'b0);
    repeat (3) @(negedge clk);
    check({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int base;
    int n;

    // 1: reset held with buttons bouncing
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #2;
      save_a_n = i[0];
      save_b_n = ~i[0];
      data_input = 4'(i);
      @(negedge clk);
      if (i % 4 == 3) begin
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_seq_busy", seq_busy, 1'b0);
        check("rst_operand_a", operand_a, 4'h0);
        check("rst_sum_out", sum_out, 5'h00);
        check("rst_tx_data", tx_data, 8'h00);
      end
    end
    @(posedge clk); #2;
    save_a_n = 1'b1;
    save_b_n = 1'b1;
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_seq_busy", seq_busy, 1'b0);
    check("post_rst_operand_b", operand_b, 4'h0);
    check("post_rst_starts", start_cnt, 0);

    // 2: 9 + 8 = 0x11
    press(1'b0, 4'h9, 8);
    push_frame(8'h31, 8'h31);
    press(1'b1, 4'h8, 8);
    wait_idle("f11");
    check("f11_operand_a", operand_a, 4'h9);
    check("f11_operand_b", operand_b, 4'h8);
    check("f11_sum", sum_out, 5'h11);
    check("f11_starts", start_cnt, 4);

    // 3: F + F = 0x1E
    press(1'b0, 4'hF, 8);
    push_frame(8'h31, 8'h45);
    press(1'b1, 4'hF, 8);
    wait_idle("f1e");
    check("f1e_sum", sum_out, 5'h1E);

    // 4: short glitch ignored, long press latches once
    press(1'b0, 4'h5, 3);
    check("glitch_operand_a", operand_a, 4'hF);
    @(posedge clk); #2;
    data_input = 4'h5;
    save_a_n = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    data_input = 4'h7;
    repeat (10) @(posedge clk);
    #2;
    save_a_n = 1'b1;
    repeat (8) @(negedge clk);
    check("long_press_operand_a", operand_a, 4'h5);
    check("long_press_no_frame", seq_busy, 1'b0);

    // 5: two B presses during a frame queue exactly one more frame
    press(1'b0, 4'h3, 8);
    base = start_cnt;
    push_frame(8'h30, 8'h33);
    push_frame(8'h30, 8'h35);
    press(1'b1, 4'h0, 8);
    check("pend_frame_in_flight", seq_busy, 1'b1);
    press(1'b1, 4'h1, 8);
    press(1'b1, 4'h2, 8);
    wait_idle("pend");
    check("pend_operand_b", operand_b, 4'h2);
    check("pend_starts", start_cnt - base, 8);
    check("pend_sum", sum_out, 5'h05);

    // 6: reset after the second byte's tx_start, then a fresh frame
    base = start_cnt;
    push_frame(8'h30, 8'h35);
    press(1'b1, 4'h2, 8);
    n = 0;
    while (start_cnt < base + 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("mid_rst_second_start_seen", start_cnt - base, 2);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_tx_start", tx_start, 1'b0);
    check("mid_rst_seq_busy", seq_busy, 1'b0);
    check("mid_rst_sum", sum_out, 5'h00);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    base = start_cnt;
    repeat (30) @(negedge clk);
    check("no_resume_starts", start_cnt - base, 0);
    check("no_resume_seq_busy", seq_busy, 1'b0);
    press(1'b0, 4'h6, 8);
    push_frame(8'h30, 8'h44);
    press(1'b1, 4'h7, 8);
    wait_idle("fresh");
    check("fresh_sum", sum_out, 5'h0D);
    check("fresh_starts", start_cnt - base, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
